// File: rtl/genvar_lane_accum_pkg.sv
// Shared types and helpers for the round-robin lane accumulator.
// The saturating add works at a fixed wide width so every lane width can share it.
package genvar_lane_accum_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam int SAT_MAX_W = 64;

  // Lane-index width, never narrower than one bit.
  function automatic int lane_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  // Saturating add.
  // The result is clamped to 2^acc_w-1; callers keep the low acc_w bits.
  function automatic logic [SAT_MAX_W-1:0] sat_add(input logic [SAT_MAX_W-1:0] acc,
                                                   input logic [SAT_MAX_W-1:0] inc,
                                                   input int unsigned         acc_w);
    logic [SAT_MAX_W:0] sum;
    logic [SAT_MAX_W:0] lim;
    sum = {1'b0, acc} + {1'b0, inc};
    lim = ((SAT_MAX_W+1)'(1) << acc_w) - (SAT_MAX_W+1)'(1);
    return (sum > lim) ? lim[SAT_MAX_W-1:0] : sum[SAT_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/genvar_lane_accum_if.sv
// Input-beat and drain-output bundle between the producer, the accumulator and the sink.
// Handshake: a transfer happens on a rising clk edge where valid && ready; a producer holding valid keeps its payload stable until that edge, and ready never depends combinationally on valid.
interface genvar_lane_accum_if #(
    parameter int W      = 16,
    parameter int ACC_W  = 20,
    parameter int LANE_W = 1
);
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_x;
    logic [W-1:0]      in_y;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [LANE_W-1:0] out_lane;

    modport slave (
        input  in_valid, in_x, in_y, out_ready,
        output in_ready, out_valid, out_sum, out_lane
    );

    modport master (
        output in_valid, in_x, in_y, out_ready,
        input  in_ready, out_valid, out_sum, out_lane
    );
endinterface

// File: rtl/genvar_lane_accum_lane_acc.sv
// One saturating accumulator lane.
// The clear input has priority over the enable input.
module lane_acc
    import genvar_lane_accum_pkg::*;
#(
    parameter int W     = 16,
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [W:0]       inc,
    output logic [ACC_W-1:0] acc
);
    logic [ACC_W-1:0]     r_acc;
    logic [SAT_MAX_W-1:0] w_sum;
    logic                 w_unused_hi;

    assign w_sum       = sat_add(SAT_MAX_W'(r_acc), SAT_MAX_W'(inc), ACC_W);
    // Saturation keeps the high bits zero, so only the low ACC_W bits are used.
    assign w_unused_hi = ^w_sum[SAT_MAX_W-1:ACC_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (clr) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= w_sum[ACC_W-1:0];
        end
    end

    assign acc = r_acc;
endmodule

// File: rtl/genvar_lane_accum.sv
// Spreads accepted (x, y) beats round-robin over LANES saturating accumulators.
// After a full frame, it drains one lane sum per output handshake.
module genvar_lane_accum
    import genvar_lane_accum_pkg::*;
#(
    parameter int LANES = 2,
    parameter int W     = 16,
    parameter int ACC_W = 20,
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    genvar_lane_accum_if.slave    bus,
    output state_t                o_dbg_state
);
    localparam int LANE_W      = lane_width(LANES);
    localparam int FRAME_BEATS = LANES * DEPTH;
    localparam int CNT_W       = $clog2(FRAME_BEATS + 1);

    state_t            r_state;
    logic [LANE_W-1:0] r_lane_ptr;
    logic [LANE_W-1:0] r_drain_ptr;
    logic [CNT_W-1:0]  r_beat_cnt;
    logic              r_hold;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_last_beat;
    logic              w_drain_hs;
    logic              w_drain_last;
    logic [W:0]        w_inc;
    logic [ACC_W-1:0]  w_acc [LANES];
    logic [ACC_W-1:0]  w_out_sum;

    // r_hold adds one idle cycle after the final drain so the cleared lanes settle first.
    assign w_in_ready   = rst_n && (r_state == ACCUM) && !r_hold;
    assign w_accept     = bus.in_valid && w_in_ready;
    assign w_last_beat  = (r_beat_cnt == CNT_W'(FRAME_BEATS - 1));
    assign w_drain_hs   = (r_state == DRAIN) && bus.out_ready;
    assign w_drain_last = w_drain_hs && (r_drain_ptr == LANE_W'(LANES - 1));
    assign w_inc        = {1'b0, bus.in_x} + {1'b0, bus.in_y};

    for (genvar i = 0; i < LANES; i++) begin : gen_lane
        logic [ACC_W-1:0] w_unused_acc;

        lane_acc #(
            .W     (W),
            .ACC_W (ACC_W)
        ) u_acc (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (w_drain_last),
            .en    (w_accept && (r_lane_ptr == LANE_W'(i))),
            .inc   (w_inc),
            .acc   (w_unused_acc)
        );

        assign w_acc[i] = gen_lane[i].u_acc.acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ACCUM;
            r_lane_ptr  <= '0;
            r_drain_ptr <= '0;
            r_beat_cnt  <= '0;
            r_hold      <= 1'b0;
        end else begin
            r_hold <= 1'b0;
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        r_lane_ptr <= (r_lane_ptr == LANE_W'(LANES - 1)) ? '0 : r_lane_ptr + 1'b1;
                        if (w_last_beat) begin
                            r_beat_cnt  <= '0;
                            r_drain_ptr <= '0;
                            r_state     <= DRAIN;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (w_drain_last) begin
                        r_drain_ptr <= '0;
                        r_lane_ptr  <= '0;
                        r_hold      <= 1'b1;
                        r_state     <= ACCUM;
                    end else if (w_drain_hs) begin
                        r_drain_ptr <= r_drain_ptr + 1'b1;
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

    always_comb begin
        w_out_sum = '0;
        if (r_state == DRAIN) begin
            for (int k = 0; k < LANES; k++) begin
                if (r_drain_ptr == LANE_W'(k)) w_out_sum = w_acc[k];
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == DRAIN);
    assign bus.out_sum   = w_out_sum;
    assign bus.out_lane  = r_drain_ptr;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_genvar_lane_accum.sv
// Bench for genvar_lane_accum: four instances cover the default, narrow-accumulator, three-lane and single-lane shapes.
// Expected lane sums come from a per-frame arithmetic model with min() saturation.
module tb_genvar_lane_accum;
  import genvar_lane_accum_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [47:0] exp_q[$];
  int bx[$];
  int by[$];

  int cfg_lanes[4] = '{2, 2, 3, 1};
  int cfg_depth[4] = '{2, 2, 1, 3};
  int cfg_accw[4]  = '{20, 17, 20, 20};

  logic        tb_in_valid[4];
  logic [15:0] tb_x[4];
  logic [15:0] tb_y[4];
  logic        tb_out_ready[4];
  logic        ob_in_ready[4];
  logic        ob_out_valid[4];
  logic [31:0] ob_sum[4];
  logic [31:0] ob_lane[4];
  state_t      dbg[4];

  genvar_lane_accum_if #(.W(16), .ACC_W(20), .LANE_W(1)) if_a ();
  genvar_lane_accum_if #(.W(16), .ACC_W(17), .LANE_W(1)) if_s ();
  genvar_lane_accum_if #(.W(16), .ACC_W(20), .LANE_W(2)) if_w ();
  genvar_lane_accum_if #(.W(16), .ACC_W(20), .LANE_W(1)) if_o ();

  assign if_a.in_valid = tb_in_valid[0];
  assign if_a.in_x = tb_x[0];
  assign if_a.in_y = tb_y[0];
  assign if_a.out_ready = tb_out_ready[0];
  assign ob_in_ready[0] = if_a.in_ready;
  assign ob_out_valid[0] = if_a.out_valid;
  assign ob_sum[0] = 32'(if_a.out_sum);
  assign ob_lane[0] = 32'(if_a.out_lane);

  assign if_s.in_valid = tb_in_valid[1];
  assign if_s.in_x = tb_x[1];
  assign if_s.in_y = tb_y[1];
  assign if_s.out_ready = tb_out_ready[1];
  assign ob_in_ready[1] = if_s.in_ready;
  assign ob_out_valid[1] = if_s.out_valid;
  assign ob_sum[1] = 32'(if_s.out_sum);
  assign ob_lane[1] = 32'(if_s.out_lane);

  assign if_w.in_valid = tb_in_valid[2];
  assign if_w.in_x = tb_x[2];
  assign if_w.in_y = tb_y[2];
  assign if_w.out_ready = tb_out_ready[2];
  assign ob_in_ready[2] = if_w.in_ready;
  assign ob_out_valid[2] = if_w.out_valid;
  assign ob_sum[2] = 32'(if_w.out_sum);
  assign ob_lane[2] = 32'(if_w.out_lane);

  assign if_o.in_valid = tb_in_valid[3];
  assign if_o.in_x = tb_x[3];
  assign if_o.in_y = tb_y[3];
  assign if_o.out_ready = tb_out_ready[3];
  assign ob_in_ready[3] = if_o.in_ready;
  assign ob_out_valid[3] = if_o.out_valid;
  assign ob_sum[3] = 32'(if_o.out_sum);
  assign ob_lane[3] = 32'(if_o.out_lane);

  genvar_lane_accum #(.LANES(2), .W(16), .ACC_W(20), .DEPTH(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a), .o_dbg_state(dbg[0]));
  genvar_lane_accum #(.LANES(2), .W(16), .ACC_W(17), .DEPTH(2)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .bus(if_s), .o_dbg_state(dbg[1]));
  genvar_lane_accum #(.LANES(3), .W(16), .ACC_W(20), .DEPTH(1)) u_dut_w (
    .clk(clk), .rst_n(rst_n), .bus(if_w), .o_dbg_state(dbg[2]));
  genvar_lane_accum #(.LANES(1), .W(16), .ACC_W(20), .DEPTH(3)) u_dut_o (
    .clk(clk), .rst_n(rst_n), .bus(if_o), .o_dbg_state(dbg[3]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_beat(input int x, input int y);
    bx.push_back(x);
    by.push_back(y);
  endtask

  task automatic send_beat(input int d, input int x, input int y);
    bit done = 1'b0;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      tb_in_valid[d] = 1'b1;
      tb_x[d] = 16'(x);
      tb_y[d] = 16'(y);
      if (ob_in_ready[d]) done = 1'b1;
    end
    check("in_ready_timeout", 64'(done), 64'd1);
    check("accum_out_valid", 64'(ob_out_valid[d]), 64'd0);
  endtask

  // Model: lane k gets every beat whose frame index is congruent to k mod LANES.
  task automatic model_frame(input int d);
    longint unsigned lane_sum[4];
    longint unsigned lim;
    lim = (64'd1 << cfg_accw[d]) - 64'd1;
    for (int l = 0; l < 4; l++) lane_sum[l] = 0;
    for (int k = 0; k < bx.size(); k++)
      lane_sum[k % cfg_lanes[d]] += longint'(bx[k]) + longint'(by[k]);
    for (int l = 0; l < cfg_lanes[d]; l++)
      exp_q.push_back({16'(l), 32'((lane_sum[l] > lim) ? lim : lane_sum[l])});
  endtask

  task automatic drain(input int d, input bit bp);
    int got = 0;
    int cyc = 0;
    bit stall = 1'b0;
    bit rdy;
    logic [31:0] p_sum = '0;
    logic [31:0] p_lane = '0;
    logic [47:0] e;
    while (got < cfg_lanes[d] && cyc < 200) begin
      @(negedge clk);
      cyc++;
      rdy = bp ? (cyc > 3 && $urandom_range(0, 2) != 0) : 1'b1;
      tb_out_ready[d] = rdy;
      tb_in_valid[d] = 1'b1;
      tb_x[d] = 16'($urandom);
      tb_y[d] = 16'($urandom);
      check("drain_out_valid", 64'(ob_out_valid[d]), 64'd1);
      check("drain_in_ready", 64'(ob_in_ready[d]), 64'd0);
      if (stall) begin
        check("hold_sum", 64'(ob_sum[d]), 64'(p_sum));
        check("hold_lane", 64'(ob_lane[d]), 64'(p_lane));
      end
      if (rdy) begin
        if (exp_q.size() == 0) begin
          check("extra_out", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          check("out_lane", 64'(ob_lane[d]), 64'(e[47:32]));
          check("out_sum", 64'(ob_sum[d]), 64'(e[31:0]));
        end
        got++;
      end
      stall = !rdy;
      p_sum = ob_sum[d];
      p_lane = ob_lane[d];
    end
    check("drain_done", 64'(got), 64'(cfg_lanes[d]));
    @(negedge clk);
    tb_in_valid[d] = 1'b0;
    tb_out_ready[d] = 1'b0;
    check("rearm_bubble", 64'(ob_in_ready[d]), 64'd0);
    check("rearm_out_valid", 64'(ob_out_valid[d]), 64'd0);
    @(negedge clk);
    check("rearm_ready", 64'(ob_in_ready[d]), 64'd1);
    check("exp_left", 64'(exp_q.size()), 64'd0);
  endtask

  // gap < 0 picks a random idle gap before each beat.
  task automatic run_frame(input int d, input int gap, input bit bp);
    int g;
    model_frame(d);
    for (int k = 0; k < bx.size(); k++) begin
      g = (gap < 0) ? $urandom_range(0, 3) : gap;
      if (k == 0) g = 0;
      for (int c = 0; c < g; c++) begin
        @(negedge clk);
        tb_in_valid[d] = 1'b0;
        check("gap_out_valid", 64'(ob_out_valid[d]), 64'd0);
      end
      send_beat(d, bx[k], by[k]);
    end
    drain(d, bp);
    bx.delete();
    by.delete();
  endtask

  task automatic random_frame(input int d);
    for (int k = 0; k < cfg_lanes[d] * cfg_depth[d]; k++)
      push_beat($urandom_range(0, 65535), $urandom_range(0, 65535));
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 4; d++) begin
      tb_in_valid[d] = 1'b0;
      tb_x[d] = '0;
      tb_y[d] = '0;
      tb_out_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      check("rst_in_ready", 64'(ob_in_ready[d]), 64'd0);
      check("rst_out_valid", 64'(ob_out_valid[d]), 64'd0);
      check("rst_out_sum", 64'(ob_sum[d]), 64'd0);
      check("rst_out_lane", 64'(ob_lane[d]), 64'd0);
      check("rst_state", 64'(dbg[d]), 64'(ACCUM));
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 4; d++) check("post_rst_ready", 64'(ob_in_ready[d]), 64'd1);

    // Basic frame: lane0 = 21+7, lane1 = 3+11.
    push_beat(10, 11); push_beat(1, 2); push_beat(3, 4); push_beat(5, 6);
    run_frame(0, 0, 1'b0);

    push_beat(10, 11); push_beat(1, 2); push_beat(3, 4); push_beat(5, 6);
    run_frame(0, 5, 1'b0);

    random_frame(0);
    run_frame(0, 0, 1'b1);

    push_beat(16'hFFFF, 16'hFFFF); push_beat(0, 0);
    push_beat(16'hFFFF, 16'hFFFF); push_beat(0, 0);
    run_frame(1, 0, 1'b0);

    push_beat(1, 0); push_beat(2, 0); push_beat(3, 0);
    run_frame(2, 0, 1'b0);
    push_beat(7, 0); push_beat(8, 0); push_beat(9, 0);
    run_frame(2, 0, 1'b0);

    random_frame(3);
    run_frame(3, 1, 1'b1);

    // Reset after lane0 has drained.
    for (int k = 0; k < 4; k++) send_beat(0, 2, 2);
    @(negedge clk);
    tb_in_valid[0] = 1'b0;
    tb_out_ready[0] = 1'b1;
    check("mid_lane0_valid", 64'(ob_out_valid[0]), 64'd1);
    check("mid_lane0_sum", 64'(ob_sum[0]), 64'd8);
    @(negedge clk);
    tb_out_ready[0] = 1'b0;
    check("mid_lane1_lane", 64'(ob_lane[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(ob_out_valid[0]), 64'd0);
    check("mid_rst_sum", 64'(ob_sum[0]), 64'd0);
    check("mid_rst_ready", 64'(ob_in_ready[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) push_beat(1, 1);
    run_frame(0, 0, 1'b0);

    for (int it = 0; it < 20; it++) begin
      int d;
      d = $urandom_range(0, 3);
      random_frame(d);
      run_frame(d, -1, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/genvar_lane_accum.md
Name: genvar_lane_accum

Overview:
- Downstream consumer for a generate-scoped producer that emits a 16-bit value pair (x, y).
- Distributes accepted (x, y) beats round-robin across LANES per-lane accumulators. The accumulators are built in a for-generate loop whose genvar is declared in the loop header, inside a named generate block.
- After a full frame, drains each lane's sum through a valid/ready output port.
- Exercises hierarchical generate naming (gen_lane[i].u_acc) and loop-scoped genvars in a block with real sequential behaviour.

Parameters:
- LANES, 2, number of accumulator lanes (>=1).
- W, 16, width of in_x and in_y.
- ACC_W, 20, accumulator and out_sum width (>= W+1).
- DEPTH, 2, beats accumulated per lane per frame (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block accepts a beat.
- in_x  input  W  first operand.
- in_y  input  W  second operand.
- out_valid  output  1  out_sum/out_lane valid.
- out_ready  input  1  consumer accepts the output.
- out_sum  output  ACC_W  drained lane sum.
- out_lane  output  $clog2(LANES) (min 1)  index of the lane being drained.

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset (rst_n low, any state, mid-frame or mid-drain) clears all state. Values held:
  - state=ACCUM, lane_ptr=0, beat_cnt=0, drain_ptr=0, all accumulators=0.
  - out_valid=0, out_sum=0, out_lane=0.
  - in_ready=0 while rst_n low.
- ACCUM state:
  - in_ready=1, out_valid=0.
  - Accept happens when in_valid && in_ready at a clock edge. On accept: acc[lane_ptr] += zero-extended (in_x + in_y), computed at W+1 bits.
  - Saturation: if the true sum exceeds 2^ACC_W-1, the accumulator holds 2^ACC_W-1. No wrap.
  - lane_ptr increments and wraps LANES-1 -> 0.
  - beat_cnt counts accepted beats; it reaches LANES*DEPTH at frame end.
  - On the accept that completes the frame: go to DRAIN next cycle, with drain_ptr=0 and beat_cnt=0.
- DRAIN state:
  - in_ready=0; input is ignored even if in_valid=1.
  - out_valid=1, out_sum=acc[drain_ptr], out_lane=drain_ptr (registered, so valid the cycle after entering DRAIN).
  - out_sum and out_lane stay stable while out_valid && !out_ready.
  - On out_valid && out_ready: drain_ptr++.
  - After the handshake with drain_ptr==LANES-1: clear all accumulators, lane_ptr=0, go to ACCUM. in_ready=1 on the following cycle, with no bubble beyond one cycle.
- Latency:
  - last input accept -> out_valid high: 1 cycle.
  - Each drained lane: 1 cycle when out_ready is held high.
- Boundary cases:
  - LANES=1: out_lane is constant 0.
  - DEPTH=1: one beat per lane per frame.
  - in_valid toggling mid-frame does not disturb lane_ptr or beat_cnt.

Decomposition:
- Shared package genvar_lane_accum_pkg:
  - typedef enum logic {ACCUM, DRAIN} state_t.
  - Function sat_add(acc, inc) returning the ACC_W-bit saturated sum.
- Sub-module lane_acc (parameters W, ACC_W). Ports: clk, rst_n, clr, en, inc[W:0], acc[ACC_W-1:0].
- Instantiation: inside named generate block gen_lane, loop "for (genvar i = 0; i < LANES; i++)", instance u_acc.
- The top reads gen_lane[i].u_acc.acc into an unpacked array for the drain mux.

Test Plan:
- Basic frame (LANES=2, DEPTH=2): beats (10,11),(1,2),(3,4),(5,6) with out_ready=1.
  - Response: (lane0, 28), then (lane1, 14). in_ready=0 for exactly 3 cycles, then 1.
- Saturation (ACC_W=17): two lane-0 beats (0xFFFF,0xFFFF) in a DEPTH=2 frame.
  - Response: lane0 out_sum=0x1FFFF; no wrap.
- Backpressure: hold out_ready=0 for 3 cycles in DRAIN.
  - Response: out_valid=1; out_sum and out_lane unchanged all 3 cycles. Input beats presented then are not accepted.
- Reset mid-drain: drop rst_n after lane0 is drained.
  - Response: immediately out_valid=0, out_sum=0, in_ready=0. After release, the next frame of (1,1)x4 yields 4 and 4.
- Wrap (LANES=3, DEPTH=1): beats (1,0),(2,0),(3,0), then a fresh frame (7,0),(8,0),(9,0).
  - Response: first frame 1,2,3 with out_lane 0,1,2; second frame 7,8,9. Confirms lane_ptr wrap and accumulator clear.
- Idle gaps: in_valid=0 for 5 cycles between beats.
  - Response: same sums as the basic frame (28, 14); beat_cnt unchanged during the gaps.
